// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first,
// and publishes sum/carry/overflow only when the whole word is complete.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cy_r;
  logic [WIDTH-1:0] res_r;

  logic [DIGIT+1:0] slice_s;
  logic [DIGIT-1:0] ssum_s;
  logic             scout_s;
  logic             smsb_s;
  logic [WIDTH-1:0] res_next_s;

  // Ripple of DIGIT full-adder cells; returns {carry into top cell, carry out, sum bits}.
  function automatic logic [DIGIT+1:0] add_slice(
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             cin
  );
    logic [DIGIT-1:0] s;
    logic             c;
    logic             cmsb;
    s    = {DIGIT{1'b0}};
    c    = cin;
    cmsb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {cmsb, c, s};
  endfunction

  // Current slice arithmetic and the result word with the new slice shifted in at the top.
  always_comb begin
    slice_s    = add_slice(a_r[DIGIT-1:0], b_r[DIGIT-1:0], cy_r);
    ssum_s     = slice_s[DIGIT-1:0];
    scout_s    = slice_s[DIGIT];
    smsb_s     = slice_s[DIGIT+1];
    res_next_s = (res_r >> DIGIT) | (WIDTH'(ssum_s) << (WIDTH - DIGIT));
  end

  // Operation sequencing, operand shifting and registered result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      cy_r     <= 1'b0;
      res_r    <= {WIDTH{1'b0}};
      sum      <= {WIDTH{1'b0}};
      carry    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // Subtraction reuses the adder: A + ~B + ~Cin.
            a_r     <= A;
            b_r     <= sub ? ~B : B;
            cy_r    <= sub ? ~Cin : Cin;
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          cy_r  <= scout_s;
          res_r <= res_next_s;
          cnt_r <= cnt_r + CW'(1'b1);
          if (cnt_r == LAST) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= res_next_s;
            carry    <= scout_s;
            overflow <= smsb_s ^ scout_s;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: runs a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4)
// instance side by side against an arithmetic reference model.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start1, start4;
  logic       sub;
  logic [7:0] A, B;
  logic       Cin;
  logic [7:0] sum1, sum4;
  logic       carry1, carry4, ovf1, ovf4, busy1, busy4, done1, done4;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8), .DIGIT(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .sum(sum1), .carry(carry1), .overflow(ovf1), .busy(busy1), .done(done1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) d4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .sum(sum4), .carry(carry4), .overflow(ovf4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[8];

  // Reference: {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                       input logic c);
    int         u, sv;
    logic       cy, ov;
    logic [7:0] r;
    if (!s) begin
      u  = int'(a) + int'(b) + int'(c);
      sv = int'($signed(a)) + int'($signed(b)) + int'(c);
      cy = (u >= 256);
    end else begin
      u  = int'(a) - int'(b) - int'(c);
      sv = int'($signed(a)) - int'($signed(b)) - int'(c);
      cy = (int'(a) >= int'(b) + int'(c));
    end
    r  = u[7:0];
    ov = (sv > 127) || (sv < -128);
    return {ov, cy, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    A   = 8'($urandom);
    B   = 8'($urandom);
    Cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // One operation on both instances; checks latency, single done and result hold.
  task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [9:0] exp);
    int n1, n4, t1, t4;
    logic [9:0] cap1, cap4;
    n1 = 0; n4 = 0; t1 = 0; t4 = 0; cap1 = 10'h0; cap4 = 10'h0;
    sub = s; A = a; B = b; Cin = c; start1 = 1'b1; start4 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    scramble();
    chk("busy1_after_accept", 32'(busy1), 32'd1);
    chk("busy4_after_accept", 32'(busy4), 32'd1);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (done1) begin n1++; t1 = cyc; cap1 = {ovf1, carry1, sum1}; end
      if (done4) begin n4++; t4 = cyc; cap4 = {ovf4, carry4, sum4}; end
    end
    chk("d1_done_count", 32'(n1), 32'd1);
    chk("d1_latency", 32'(t1), 32'd8);
    chk("d4_done_count", 32'(n4), 32'd1);
    chk("d4_latency", 32'(t4), 32'd2);
    chk("d1_result", 32'(cap1), 32'(exp));
    chk("d4_result", 32'(cap4), 32'(exp));
    chk("d1_result_hold", 32'({ovf1, carry1, sum1}), 32'(exp));
  endtask

  initial begin
    int nd, td;
    logic [9:0] cap;
    vectors = 0; miscompares = 0;
    tbl[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 10'h100};
    tbl[1] = '{1'b0, 8'h7F, 8'h00, 1'b1, 10'h280};
    tbl[2] = '{1'b1, 8'h05, 8'h07, 1'b0, 10'h0FE};
    tbl[3] = '{1'b1, 8'h07, 8'h05, 1'b1, 10'h101};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 10'h37F};
    tbl[5] = '{1'b0, 8'h80, 8'h80, 1'b0, 10'h300};
    tbl[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 10'h0FF};
    tbl[7] = '{1'b0, 8'h3C, 8'hA5, 1'b1, 10'h0E2};

    rst = 1'b1; start1 = 1'b1; start4 = 1'b1; sub = 1'b0; A = 8'h12; B = 8'h34; Cin = 1'b0;
    tick(); tick();
    chk("reset_d1", 32'({sum1, carry1, ovf1, busy1, done1}), 32'd0);
    chk("reset_d4", 32'({sum4, carry4, ovf4, busy4, done4}), 32'd0);
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp);

    for (int i = 0; i < 150; i++) begin
      logic s, c;
      logic [7:0] a, b;
      s = 1'($urandom); c = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      do_op(s, a, b, c, model(s, a, b, c));
    end

    // start pulsed mid-run must be ignored
    nd = 0; td = 0; cap = 10'h0;
    sub = 1'b0; A = 8'h12; B = 8'h34; Cin = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick();
    sub = 1'b1; A = 8'hFF; B = 8'h01; Cin = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int cyc = 5; cyc <= 20; cyc++) begin
      tick();
      if (done1) begin nd++; td = cyc; cap = {ovf1, carry1, sum1}; end
    end
    chk("midrun_done_count", 32'(nd), 32'd1);
    chk("midrun_latency", 32'(td), 32'd8);
    chk("midrun_result", 32'(cap), 32'(model(1'b0, 8'h12, 8'h34, 1'b0)));

    // start held through the done cycle starts the next op immediately
    nd = 0; td = 0; cap = 10'h0;
    sub = 1'b1; A = 8'h40; B = 8'hC1; Cin = 1'b0; start1 = 1'b1;
    tick();
    sub = 1'b0; A = 8'h9A; B = 8'h77; Cin = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      if (done1) begin nd++; td = cyc; cap = {ovf1, carry1, sum1}; end
    end
    chk("b2b_first_done_count", 32'(nd), 32'd1);
    chk("b2b_first_latency", 32'(td), 32'd8);
    chk("b2b_first_result", 32'(cap), 32'(model(1'b1, 8'h40, 8'hC1, 1'b0)));
    tick();
    start1 = 1'b0;
    chk("b2b_second_busy", 32'(busy1), 32'd1);
    nd = 0; td = 0; cap = 10'h0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (done1) begin nd++; td = cyc; cap = {ovf1, carry1, sum1}; end
    end
    chk("b2b_second_done_count", 32'(nd), 32'd1);
    chk("b2b_second_latency", 32'(td), 32'd8);
    chk("b2b_second_result", 32'(cap), 32'(model(1'b0, 8'h9A, 8'h77, 1'b1)));

    // reset four cycles into a run aborts with no done
    sub = 1'b0; A = 8'h55; B = 8'h22; Cin = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_sum", 32'(sum1), 32'd0);
    chk("abort_flags", 32'({carry1, ovf1}), 32'd0);
    nd = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (done1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    do_op(1'b1, 8'h7F, 8'hFF, 1'b0, model(1'b1, 8'h7F, 8'hFF, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
